dm_cache_ctrl_arb: RTL and testbench

- Read-only direct-mapped cache controller that shares one 8-line cache between NUM_REQ requesters using round-robin arbitration.
- Performs tag lookup. On a miss, runs a fill from the backing RAM over a variable-latency req/ack interface, then returns the data to the owning requester.
- Sits between core-side requesters and the RAM model. Replaces the free-running per-clock lookup with a sequenced, handshaked flow.

---
 rtl/dm_cache_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/dm_cache_ctrl_arb.sv | 153 +++++++++++++++
 tb/tb_dm_cache_ctrl_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// rtl/dm_cache_pkg.sv - shared types, default widths and address helpers for the cache controller
package dm_cache_pkg;

   localparam int DEF_NUM_REQ = 2;
   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_INDEX_W = 3;
   localparam int DEF_CNT_W   = 16;
   localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      FILL   = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Line index: low address bits select the direct-mapped line.
   function automatic logic [DEF_INDEX_W-1:0] idx_of(input logic [DEF_ADDR_W-1:0] addr);
      return addr[DEF_INDEX_W-1:0];
   endfunction

   // Tag: everything above the index, compared in full.
   function automatic logic [DEF_TAG_W-1:0] tag_of(input logic [DEF_ADDR_W-1:0] addr);
      return addr[DEF_ADDR_W-1:DEF_INDEX_W];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   gnt_idx,
   output logic               gnt_valid
);

   logic [PTR_W-1:0] pos;

   // Scan from farthest to nearest so the nearest set request at/after ptr wins.
   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      pos       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (req[pos]) begin
            gnt_valid = 1'b1;
            gnt_idx   = pos;
         end
      end
      if (gnt_valid) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/dm_cache_ctrl_arb.sv
// rtl/dm_cache_ctrl_arb.sv - read-only direct-mapped cache shared by round-robin requesters
module dm_cache_ctrl_arb
   import dm_cache_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int INDEX_W = DEF_INDEX_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_hit,
   output logic                      mem_req,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic                      mem_ack,
   input  logic [DATA_W-1:0]         mem_data,
   output logic                      busy,
   output logic [CNT_W-1:0]          hit_cnt,
   output logic [CNT_W-1:0]          miss_cnt
);

   localparam int LINES = 2 ** INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, owner_q, gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_any;
   logic [ADDR_W-1:0]  addr_q;
   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [DATA_W-1:0]  data_q [LINES];
   logic [INDEX_W-1:0] lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic               lk_hit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_any)
   );

   assign lk_idx = addr_q[INDEX_W-1:0];
   assign lk_tag = addr_q[ADDR_W-1:INDEX_W];
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign busy   = (state_q != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus the combinational grant and response strobes.
   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      resp_valid = '0;
      case (state_q)
         IDLE: begin
            req_ready = gnt;
            if (gnt_any) begin
               state_d = LOOKUP;
            end
         end
         LOOKUP: state_d = lk_hit ? RESP : FILL;
         FILL: begin
            if (mem_ack) begin
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid[owner_q] = 1'b1;
            state_d             = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the granted request and advance the round-robin pointer past it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         owner_q  <= '0;
         addr_q   <= '0;
      end else if (state_q == IDLE && gnt_any) begin
         addr_q   <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
         owner_q  <= gnt_idx;
         rr_ptr_q <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

   // Lookup result, fill handshake, valid bits and saturating counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= '0;
         resp_data <= '0;
         resp_hit  <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         case (state_q)
            LOOKUP: begin
               if (lk_hit) begin
                  resp_data <= data_q[lk_idx];
                  resp_hit  <= 1'b1;
                  if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
               end else begin
                  mem_req  <= 1'b1;
                  mem_addr <= addr_q;
                  if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
               end
            end
            FILL: begin
               if (mem_ack) begin
                  valid_q[lk_idx] <= 1'b1;
                  resp_data       <= mem_data;
                  resp_hit        <= 1'b0;
                  mem_req         <= 1'b0;
               end
            end
            RESP:    resp_hit <= 1'b0;
            default: ;
         endcase
      end
   end

   // Line storage; a reset arriving with the ack abandons the write.
   always_ff @(posedge clk) begin
      if (!rst && state_q == FILL && mem_ack) begin
         tag_q[lk_idx]  <= lk_tag;
         data_q[lk_idx] <= mem_data;
      end
   end

endmodule

// File: tb/tb_dm_cache_ctrl_arb.sv
// tb/tb_dm_cache_ctrl_arb.sv - scoreboard bench for the shared direct-mapped cache controller
module tb_dm_cache_ctrl_arb;

   localparam int NR  = 2;
   localparam int AW  = 8;
   localparam int DW  = 8;
   localparam int IW  = 3;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR-1:0]    req_ready, resp_valid;
   logic [DW-1:0]    resp_data;
   logic             resp_hit, mem_req, busy;
   logic [AW-1:0]    mem_addr;
   logic             mem_ack = 1'b0;
   logic [DW-1:0]    mem_data = '0;
   logic [CW-1:0]    hit_cnt, miss_cnt;

   dm_cache_ctrl_arb #(
      .NUM_REQ (NR), .ADDR_W (AW), .DATA_W (DW), .INDEX_W (IW), .CNT_W (CW)
   ) dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_addr (req_addr), .req_ready (req_ready),
      .resp_valid (resp_valid), .resp_data (resp_data), .resp_hit (resp_hit),
      .mem_req (mem_req), .mem_addr (mem_addr), .mem_ack (mem_ack), .mem_data (mem_data),
      .busy (busy), .hit_cnt (hit_cnt), .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         owner;
      logic [7:0] data;
      logic       hit;
      int         gcyc;
      int         hc;
      int         mc;
   } exp_t;

   int         errors = 0;
   int         checks = 0;
   exp_t       exp_q[$];
   logic [7:0] fill_q[$];
   logic [7:0] ram [256];
   bit         mvalid [8];
   int         mtag [8];
   int         mptr = 0, mhits = 0, mmiss = 0;
   int         ncyc = 0, last_ack = -1;
   bit         auto_ram = 1'b1, rand_lat = 1'b0, spurious = 1'b0;
   int         ram_lat = 3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: expected event did not occur", name);
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int p);
      for (int k = 0; k < NR; k++) begin
         if (v[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   // Reference model and scoreboard monitor.
   initial begin : monitor
      exp_t e;
      int   g, a, idx, tg, want;
      forever begin
         @(negedge clk);
         ncyc++;
         if (rst) begin
            exp_q.delete();
            fill_q.delete();
            for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
            mptr = 0; mhits = 0; mmiss = 0; last_ack = -1;
         end else begin
            if (exp_q.size() != 0) begin
               if (req_ready != '0) check("ready_while_busy", 32'(req_ready), 32'd0);
               if (exp_q[0].hit && mem_req) check("mem_req_on_hit", 32'(mem_req), 32'd0);
               if (ncyc - exp_q[0].gcyc > 60) begin
                  fail("resp_timeout");
                  void'(exp_q.pop_front());
               end
            end else if (req_valid != '0) begin
               g = pick(req_valid, mptr);
               check("grant", 32'(req_ready), 32'(1) << g);
               mptr = (g + 1) % NR;
               a    = int'(req_addr[g*AW +: AW]);
               idx  = a % 8;
               tg   = a / 8;
               e.owner = g; e.data = ram[a]; e.gcyc = ncyc;
               if (mvalid[idx] && mtag[idx] == tg) begin
                  e.hit = 1'b1;
                  mhits = (mhits < SAT) ? mhits + 1 : SAT;
               end else begin
                  e.hit = 1'b0;
                  mmiss = (mmiss < SAT) ? mmiss + 1 : SAT;
                  mvalid[idx] = 1'b1;
                  mtag[idx]   = tg;
                  fill_q.push_back(8'(a));
               end
               e.hc = mhits; e.mc = mmiss;
               exp_q.push_back(e);
            end else begin
               check("idle_no_grant", 32'(req_ready), 32'd0);
            end
            if (mem_req && mem_ack) last_ack = ncyc;
            if (resp_valid != '0) begin
               if (exp_q.size() == 0) begin
                  fail("unexpected_resp");
               end else begin
                  e = exp_q.pop_front();
                  want = e.hit ? e.gcyc + 2 : last_ack + 1;
                  check("resp_owner", 32'(resp_valid), 32'(1) << e.owner);
                  check("resp_data", 32'(resp_data), 32'(e.data));
                  check("resp_hit", 32'(resp_hit), 32'(e.hit));
                  check("hit_cnt", 32'(hit_cnt), 32'(e.hc));
                  check("miss_cnt", 32'(miss_cnt), 32'(e.mc));
                  check("resp_cycle", 32'(ncyc), 32'(want));
               end
            end
         end
      end
   end

   // Backing RAM: variable latency acks, plus stray acks while the controller is idle.
   initial begin : ram_model
      int lat;
      forever begin
         @(negedge clk);
         if (rst || !auto_ram) continue;
         if (mem_req) begin
            if (fill_q.size() == 0) fail("fill_unexpected");
            else check("mem_addr", 32'(mem_addr), 32'(fill_q.pop_front()));
            lat = rand_lat ? $urandom_range(1, 4) : ram_lat;
            repeat (lat) @(posedge clk);
            #1 mem_ack = 1'b1; mem_data = ram[mem_addr];
            @(posedge clk);
            #1 mem_ack = 1'b0; mem_data = 8'h00;
         end else if (spurious && !busy && ($urandom % 6) == 0) begin
            @(posedge clk);
            #1 mem_ack = 1'b1; mem_data = 8'hEE;
            @(posedge clk);
            #1 mem_ack = 1'b0; mem_data = 8'h00;
         end
      end
   end

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !busy;
      end
      if (!done) fail("idle_timeout");
      @(posedge clk); #1;
   endtask

   task automatic issue(input int r, input logic [7:0] a);
      bit got = 1'b0;
      req_addr[r*AW +: AW] = a;
      req_valid[r] = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = req_ready[r];
      end
      if (!got) fail("issue_grant");
      @(posedge clk); #1 req_valid[r] = 1'b0;
      wait_idle();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int grants;
      logic [NR-1:0] g;
      for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
      ram[8'h2A] = 8'h5C;
      ram[8'h32] = 8'hA7;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", 32'(resp_data), 32'd0);
      check("rst_resp_hit", 32'(resp_hit), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
      check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
      @(posedge clk); #1;

      // Cold miss, then a hit on the same address.
      issue(0, 8'h2A);
      check("t1_miss_cnt", 32'(miss_cnt), 32'd1);
      check("t1_data_hold", 32'(resp_data), 32'h5C);
      check("t1_hit_low", 32'(resp_hit), 32'd0);
      issue(0, 8'h2A);
      check("t2_hit_cnt", 32'(hit_cnt), 32'd1);

      // Conflicting tag on index 2 evicts, then the original misses again.
      ram_lat = 1;
      issue(0, 8'h32);
      issue(0, 8'h2A);
      check("t3_miss_cnt", 32'(miss_cnt), 32'd3);

      // Both requesters continuously asking: grants alternate.
      req_addr  = {8'h2A, 8'h2A};
      req_valid = 2'b11;
      grants    = 0;
      for (int i = 0; i < 40 && grants < 4; i++) begin
         @(negedge clk);
         if (req_ready != '0) grants++;
      end
      if (grants < 4) fail("t4_grants");
      @(posedge clk); #1 req_valid = '0;
      wait_idle();

      // Reset in the second fill cycle, then a late ack.
      auto_ram = 1'b0;
      req_addr[AW-1:0] = 8'h45;
      req_valid[0] = 1'b1;
      @(negedge clk);
      check("t5_grant", 32'(req_ready), 32'd1);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("t5_mem_req_before", 32'(mem_req), 32'd1);
      @(posedge clk); #1 rst = 1'b0; mem_ack = 1'b1; mem_data = 8'h77;
      @(negedge clk);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_mem_req", 32'(mem_req), 32'd0);
      check("t5_hit_cnt", 32'(hit_cnt), 32'd0);
      check("t5_miss_cnt", 32'(miss_cnt), 32'd0);
      @(posedge clk); #1 mem_ack = 1'b0; mem_data = 8'h00;
      @(negedge clk);
      check("t5_busy_after_ack", 32'(busy), 32'd0);
      @(posedge clk); #1 auto_ram = 1'b1;
      issue(0, 8'h45);
      check("t5_remiss", 32'(miss_cnt), 32'd1);

      // Hit counter saturation.
      for (int i = 0; i < 20; i++) issue(i % NR, 8'h45);
      check("t6_hit_sat", 32'(hit_cnt), 32'(SAT));

      // Randomised traffic with stray acks and variable fill latency.
      spurious = 1'b1;
      rand_lat = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         g = req_ready;
         @(posedge clk); #1;
         for (int r = 0; r < NR; r++) begin
            if (g[r] || !req_valid[r]) begin
               req_valid[r] = ($urandom % 3) != 0;
               req_addr[r*AW +: AW] = (($urandom % 4) == 0) ? 8'h2A :
                  (8'($urandom_range(0, 63)) ^ ((($urandom % 8) == 0) ? 8'hC0 : 8'h00));
            end else if (($urandom % 10) == 0) begin
               req_valid[r] = 1'b0;
            end
         end
      end
      req_valid = '0;
      wait_idle();
      spurious = 1'b0;
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
